// File: rtl/kernel_jacobi_2d_addr_gen_if.sv
// rtl/kernel_jacobi_2d_addr_gen_if.sv - stencil address stream interface
interface kernel_jacobi_2d_addr_gen_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] addr_out;
  logic [2:0]        addr_tap;
  logic              addr_last;
  logic              addr_valid;
  logic              addr_ready;

  modport master (
    output addr_out, addr_tap, addr_last, addr_valid,
    input  addr_ready
  );

  modport slave (
    input  addr_out, addr_tap, addr_last, addr_valid,
    output addr_ready
  );
endinterface

// File: rtl/kernel_jacobi_2d_addr_gen.sv
// rtl/kernel_jacobi_2d_addr_gen.sv - jacobi-2d 5-point stencil address generator
module kernel_jacobi_2d_addr_gen #(
  parameter int ROW_W  = 10,
  parameter int COL_W  = 11,
  parameter int ADDR_W = 20
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  input  logic [ROW_W-1:0]  n_rows,
  input  logic [COL_W-1:0]  n_cols,
  output logic [ROW_W-1:0]  mul_din0,
  output logic [COL_W-1:0]  mul_din1,
  input  logic [ADDR_W-1:0] mul_dout,
  kernel_jacobi_2d_addr_gen_if.master addr_if
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROWBASE = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [COL_W-1:0]  cols_q, cols_d;
  logic [ROW_W-1:0]  i_q, i_d;
  logic [COL_W-1:0]  j_q, j_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [2:0]        addr_tap_q, addr_tap_d;
  logic              addr_last_q, addr_last_d;
  logic              addr_valid_q, addr_valid_d;
  logic              done_q, done_d;
  logic [ROW_W-1:0]  mul_din0_q, mul_din0_d;
  logic [COL_W-1:0]  mul_din1_q, mul_din1_d;
  logic              xfer;
  logic [2:0]        tap_inc;

  // Linear address of one stencil tap around (row base, column j).
  function automatic logic [ADDR_W-1:0] tap_addr(
    input logic [ADDR_W-1:0] base,
    input logic [COL_W-1:0]  cols,
    input logic [COL_W-1:0]  j,
    input logic [2:0]        tap
  );
    logic [ADDR_W-1:0] c;
    logic [ADDR_W-1:0] jx;
    c  = ADDR_W'(cols);
    jx = ADDR_W'(j);
    case (tap)
      3'd0:    tap_addr = base - c + jx;
      3'd1:    tap_addr = base + jx - ADDR_W'(1);
      3'd2:    tap_addr = base + jx;
      3'd3:    tap_addr = base + jx + ADDR_W'(1);
      default: tap_addr = base + c + jx;
    endcase
  endfunction

  assign xfer    = addr_valid_q & addr_if.addr_ready;
  assign tap_inc = addr_tap_q + 3'd1;

  // Next-state, counters and the registered stream outputs.
  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    i_d          = i_q;
    j_d          = j_q;
    base_d       = base_q;
    addr_out_d   = addr_out_q;
    addr_tap_d   = addr_tap_q;
    addr_last_d  = addr_last_q;
    addr_valid_d = addr_valid_q;
    done_d       = 1'b0;
    mul_din0_d   = mul_din0_q;
    mul_din1_d   = mul_din1_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          rows_d = n_rows;
          cols_d = n_cols;
          i_d    = ROW_W'(1);
          j_d    = COL_W'(1);
          if (n_rows < ROW_W'(3) || n_cols < COL_W'(3)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ROWBASE;
            mul_din0_d = ROW_W'(1);
            mul_din1_d = n_cols;
          end
        end
      end
      ROWBASE: begin
        // The product is combinational, so the first tap of the row can be
        // registered in the same cycle as the base.
        base_d       = mul_dout;
        addr_out_d   = tap_addr(mul_dout, cols_q, j_q, 3'd0);
        addr_tap_d   = 3'd0;
        addr_last_d  = 1'b0;
        addr_valid_d = 1'b1;
        state_d      = EMIT;
      end
      EMIT: begin
        if (xfer) begin
          if (addr_tap_q != 3'd4) begin
            addr_tap_d  = tap_inc;
            addr_out_d  = tap_addr(base_q, cols_q, j_q, tap_inc);
            addr_last_d = (tap_inc == 3'd4) && (i_q == rows_q - ROW_W'(2)) &&
                          (j_q == cols_q - COL_W'(2));
          end else if (j_q < cols_q - COL_W'(2)) begin
            j_d         = j_q + COL_W'(1);
            addr_tap_d  = 3'd0;
            addr_out_d  = tap_addr(base_q, cols_q, j_q + COL_W'(1), 3'd0);
            addr_last_d = 1'b0;
          end else if (i_q < rows_q - ROW_W'(2)) begin
            i_d          = i_q + ROW_W'(1);
            j_d          = COL_W'(1);
            mul_din0_d   = i_q + ROW_W'(1);
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
            state_d      = ROWBASE;
          end else begin
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
            done_d       = 1'b1;
            state_d      = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      i_q          <= '0;
      j_q          <= '0;
      base_q       <= '0;
      addr_out_q   <= '0;
      addr_tap_q   <= '0;
      addr_last_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      mul_din0_q   <= '0;
      mul_din1_q   <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      i_q          <= i_d;
      j_q          <= j_d;
      base_q       <= base_d;
      addr_out_q   <= addr_out_d;
      addr_tap_q   <= addr_tap_d;
      addr_last_q  <= addr_last_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
      mul_din0_q   <= mul_din0_d;
      mul_din1_q   <= mul_din1_d;
    end
  end

  assign ap_idle            = (state_q == IDLE);
  assign ap_done            = done_q;
  assign ap_ready           = done_q;
  assign mul_din0           = mul_din0_q;
  assign mul_din1           = mul_din1_q;
  assign addr_if.addr_out   = addr_out_q;
  assign addr_if.addr_tap   = addr_tap_q;
  assign addr_if.addr_last  = addr_last_q;
  assign addr_if.addr_valid = addr_valid_q;

endmodule

// File: tb/tb_kernel_jacobi_2d_addr_gen.sv
// tb/tb_kernel_jacobi_2d_addr_gen.sv - directed bench for the stencil address generator
module tb_kernel_jacobi_2d_addr_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_done, ap_ready;
  logic [9:0]  n_rows = '0;
  logic [10:0] n_cols = '0;
  logic [9:0]  mul_din0;
  logic [10:0] mul_din1;
  logic [19:0] mul_dout;

  int checks = 0;
  int errors = 0;
  int xq[$];
  int ref_4x5[$];
  int done_cyc;

  kernel_jacobi_2d_addr_gen_if #(.ADDR_W(20)) s_if ();

  assign mul_dout = 20'(mul_din0 * mul_din1);

  kernel_jacobi_2d_addr_gen dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .ap_ready (ap_ready),
    .n_rows   (n_rows),
    .n_cols   (n_cols),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .addr_if  (s_if)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int cols, input int n);
    int w, p, i, j, base;
    w = cols - 2;
    p = n / 5;
    i = p / w + 1;
    j = p % w + 1;
    base = i * cols;
    case (n % 5)
      0:       return base - cols + j;
      1:       return base + j - 1;
      2:       return base + j;
      3:       return base + j + 1;
      default: return base + cols + j;
    endcase
  endfunction

  task automatic start_run(input int rows, input int cols);
    int guard = 0;
    while (!ap_idle && guard < 10) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    chk("start_idle", ap_idle, 1);
    n_rows   = 10'(rows);
    n_cols   = 11'(cols);
    ap_start = 1'b1;
  endtask

  // Watches one run from the accepting edge to ap_done, checking every
  // transfer against the stencil model and the stream hold rule.
  task automatic collect(input int rows, input int cols, input bit bp,
                         input bit hold, input int mid_cols);
    int cyc = 0, nx = 0, row = 0, total, firstv = -1, firstx = -1, lastx = -1;
    bit stall = 0, rdy;
    int p_addr, p_tap, p_last;
    total = (rows < 3 || cols < 3) ? 0 : 5 * (rows - 2) * (cols - 2);
    done_cyc = -1;
    xq.delete();
    while (cyc < 20000 && done_cyc < 0) begin
      @(posedge ap_clk); #1;
      cyc++;
      if (cyc == 1 && !hold) ap_start = 1'b0;
      if (mid_cols > 0 && cyc == 5) n_cols = 11'(mid_cols);
      if (stall) begin
        chk("hold_valid", s_if.addr_valid, 1);
        chk("hold_addr", s_if.addr_out, p_addr);
        chk("hold_tap", s_if.addr_tap, p_tap);
        chk("hold_last", s_if.addr_last, p_last);
      end
      if (!ap_idle && !s_if.addr_valid && !ap_done) begin
        row++;
        chk("rowbase_din0", mul_din0, row);
        chk("rowbase_din1", mul_din1, cols);
      end
      if (s_if.addr_valid && firstv < 0) firstv = cyc;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.addr_ready = rdy;
      if (s_if.addr_valid && rdy) begin
        xq.push_back(int'(s_if.addr_out));
        if (nx < total) begin
          chk("addr", s_if.addr_out, exp_addr(cols, nx));
          chk("tap", s_if.addr_tap, nx % 5);
        end
        chk("last", s_if.addr_last, (nx == total - 1));
        if (firstx < 0) firstx = cyc;
        lastx = cyc;
        nx++;
      end
      stall  = s_if.addr_valid && !rdy;
      p_addr = int'(s_if.addr_out);
      p_tap  = int'(s_if.addr_tap);
      p_last = int'(s_if.addr_last);
      if (ap_done) begin
        done_cyc = cyc;
        chk("ap_ready_with_done", ap_ready, 1);
      end
    end
    s_if.addr_ready = 1'b1;
    chk("done_seen", (done_cyc >= 0), 1);
    chk("xfer_count", nx, total);
    if (total > 0) begin
      chk("first_valid_cyc", firstv, 2);
      chk("done_after_last", done_cyc, lastx + 1);
      if (!bp) chk("row_bubbles", lastx - firstx + 1, total + rows - 3);
    end else begin
      chk("degen_done_cyc", done_cyc, 1);
      chk("degen_no_valid", firstv, -1);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_valid", s_if.addr_valid, 0);
    chk("rst_last", s_if.addr_last, 0);
    chk("rst_addr", s_if.addr_out, 0);
    chk("rst_tap", s_if.addr_tap, 0);
    chk("rst_din0", mul_din0, 0);
    chk("rst_din1", mul_din1, 0);
  endtask

  initial begin
    int lst5[5], fst5[5], r998[5], r3x3[5], r4x3[10], big[5];
    int bad;
    fst5 = '{1, 5, 6, 7, 11};
    lst5 = '{8, 12, 13, 14, 18};
    r998 = '{2992, 2994, 2995, 2996, 2998};
    r3x3 = '{1, 3, 4, 5, 7};
    r4x3 = '{1, 3, 4, 5, 7, 4, 6, 7, 8, 10};
    big  = '{1, 1000, 1001, 1002, 2001};
    s_if.addr_ready = 1'b1;

    repeat (3) @(posedge ap_clk);
    #1;
    chk_reset_values();
    ap_rst = 1'b0;

    // 4x5 grid, always ready
    start_run(4, 5);
    collect(4, 5, 0, 0, 0);
    ref_4x5 = xq;
    for (int k = 0; k < 5; k++) begin
      chk("g4x5_first", (xq.size() > k) ? xq[k] : -1, fst5[k]);
      chk("g4x5_last", (xq.size() >= 30) ? xq[25 + k] : -1, lst5[k]);
    end

    // 4x5 grid with random backpressure
    start_run(4, 5);
    collect(4, 5, 1, 0, 0);
    chk("bp_count", xq.size(), ref_4x5.size());
    for (int k = 0; k < ref_4x5.size() && k < xq.size(); k++)
      chk("bp_same_seq", xq[k], ref_4x5[k]);

    // degenerate grids
    start_run(2, 100);
    collect(2, 100, 0, 0, 0);
    start_run(3, 3);
    collect(3, 3, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      chk("g3x3", (xq.size() > k) ? xq[k] : -1, r3x3[k]);

    // many rows: every row transition exercises the multiplier operands
    start_run(1000, 3);
    collect(1000, 3, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      chk("row998", (xq.size() > 4985 + k) ? xq[4985 + k] : -1, r998[k]);

    // start held high, n_cols changed mid-run, then immediate restart
    start_run(4, 5);
    collect(4, 5, 0, 1, 3);
    for (int k = 0; k < ref_4x5.size() && k < xq.size(); k++)
      chk("hold_same_seq", xq[k], ref_4x5[k]);
    @(posedge ap_clk); #1;
    chk("restart_idle", ap_idle, 1);
    collect(4, 3, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      chk("restart_4x3", (xq.size() > k) ? xq[k] : -1, r4x3[k]);

    // large grid: wide product, then reset while emitting
    start_run(1000, 1000);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    chk("big_din0", mul_din0, 1);
    chk("big_din1", mul_din1, 1000);
    for (int k = 0; k < 5; k++) begin
      @(posedge ap_clk); #1;
      chk("big_valid", s_if.addr_valid, 1);
      chk("big_addr", s_if.addr_out, big[k]);
    end
    repeat (30) @(posedge ap_clk);
    #1;
    chk("pre_rst_emit", s_if.addr_valid, 1);
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    chk_reset_values();
    ap_rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ap_clk); #1;
      if (ap_done || s_if.addr_valid || !ap_idle) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
